// File: rtl/text_fetch_ctrl.sv
// Text-mode fetch controller: shares a single-port text buffer between the video
// character fetch and a host write port, and aligns pixel/sync outputs.
module text_fetch_ctrl #(
   parameter int COLS = 80,
   parameter int ROWS = 30
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  hcount,
   input  logic [9:0]  vcount,
   input  logic        active,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        host_req,
   input  logic [11:0] host_addr,
   input  logic [7:0]  host_data,
   output logic        host_ack,
   output logic [11:0] tb_addr,
   output logic        tb_we,
   output logic [7:0]  tb_wdata,
   input  logic [7:0]  tb_rdata,
   output logic [7:0]  chr_val,
   output logic [3:0]  row,
   output logic [2:0]  col,
   input  logic        pixel_in,
   output logic        pixel_out,
   output logic        hsync_out,
   output logic        vsync_out
);

   localparam logic [11:0] COLS_W = 12'(COLS);
   localparam logic [31:0] CELLS  = 32'(COLS * ROWS);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } host_state_e;

   host_state_e     state_q, state_d;
   logic            video_slot, wr_cycle, wr_en;
   logic [11:0]     vid_addr;
   logic [11:0]     last_addr_q, last_addr_d;
   logic            vslot_q, vslot_d;
   logic [7:0]      chr_q, chr_d;
   logic [1:0][3:0] row_q, row_d;
   logic [1:0][2:0] col_q, col_d;
   logic [2:0]      act_q, act_d;
   logic [3:0]      hs_q, hs_d;
   logic [3:0]      vs_q, vs_d;
   logic            pix_q, pix_d;
   logic            unused_vcount;

   assign unused_vcount = vcount[9];
   assign video_slot    = active && (hcount[2:0] == 3'd0);
   assign vid_addr      = {7'd0, vcount[8:4]} * COLS_W + {5'd0, hcount[9:3]};

   // Host port is a four-phase handshake: the host raises host_req with address and
   // data stable, one write is issued in the first free slot, host_ack stays high
   // until host_req falls, and host_ack falls the cycle after that.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (host_req && !video_slot) state_d = ACK;
         ACK:     if (!host_req) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Buffer port outputs are combinational so a video read lands in its own slot;
   // reset forces them idle even while the raster inputs keep running.
   always_comb begin
      wr_cycle = 1'b0;
      host_ack = 1'b0;
      case (state_q)
         IDLE:    wr_cycle = rst_n && host_req && !video_slot;
         ACK:     host_ack = 1'b1;
         default: wr_cycle = 1'b0;
      endcase
      wr_en    = wr_cycle && ({20'd0, host_addr} < CELLS);
      tb_we    = wr_en;
      tb_wdata = wr_en ? host_data : 8'h00;
      if (!rst_n) begin
         tb_addr = 12'd0;
      end else if (video_slot) begin
         tb_addr = vid_addr;
      end else if (wr_en) begin
         tb_addr = host_addr;
      end else begin
         tb_addr = last_addr_q;
      end
   end

   always_comb begin
      last_addr_d = video_slot ? vid_addr : last_addr_q;
      vslot_d     = video_slot;
      chr_d       = vslot_q ? tb_rdata : chr_q;
      row_d       = {row_q[0], vcount[3:0]};
      col_d       = {col_q[0], hcount[2:0]};
      act_d       = {act_q[1:0], active};
      hs_d        = {hs_q[2:0], hsync_in};
      vs_d        = {vs_q[2:0], vsync_in};
      pix_d       = pixel_in && act_q[2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_addr_q <= 12'd0;
         vslot_q     <= 1'b0;
         chr_q       <= 8'h20;
         row_q       <= '0;
         col_q       <= '0;
         act_q       <= '0;
         hs_q        <= '1;
         vs_q        <= '1;
         pix_q       <= 1'b0;
      end else begin
         last_addr_q <= last_addr_d;
         vslot_q     <= vslot_d;
         chr_q       <= chr_d;
         row_q       <= row_d;
         col_q       <= col_d;
         act_q       <= act_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         pix_q       <= pix_d;
      end
   end

   assign chr_val   = chr_q;
   assign row       = row_q[1];
   assign col       = col_q[1];
   assign pixel_out = pix_q;
   assign hsync_out = hs_q[3];
   assign vsync_out = vs_q[3];

endmodule

// File: tb/tb_text_fetch_ctrl.sv
// Bench for text_fetch_ctrl: text buffer and character ROM models, vector table,
// hand sequences for handshake/reset corners, and randomized video and host traffic.
module tb_text_fetch_ctrl;

   localparam int COLS  = 80;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;
   localparam int P1    = 600;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  hcount, vcount;
   logic        active, hsync_in, vsync_in;
   logic        host_req;
   logic [11:0] host_addr;
   logic [7:0]  host_data;
   logic        host_ack;
   logic [11:0] tb_addr;
   logic        tb_we;
   logic [7:0]  tb_wdata;
   logic [7:0]  tb_rdata;
   logic [7:0]  chr_val;
   logic [3:0]  row;
   logic [2:0]  col;
   logic        pixel_in;
   logic        pixel_out, hsync_out, vsync_out;

   text_fetch_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .active(active),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .host_req(host_req),
      .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
      .tb_addr(tb_addr), .tb_we(tb_we), .tb_wdata(tb_wdata), .tb_rdata(tb_rdata),
      .chr_val(chr_val), .row(row), .col(col), .pixel_in(pixel_in),
      .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out)
   );

   always #5 clk = ~clk;

   // ---------------- external models ----------------
   bit [7:0] buf_mem [4096];
   bit       buf_wr  [4096];

   function automatic logic [7:0] init_val(input logic [11:0] a);
      return 8'(32'(a) * 7 + 3);
   endfunction

   function automatic logic [7:0] buf_val(input logic [11:0] a);
      return buf_wr[a] ? buf_mem[a] : init_val(a);
   endfunction

   function automatic logic rom_bit(input logic [7:0] c, input logic [3:0] r, input logic [2:0] cl);
      return c[cl] ^ r[0];
   endfunction

   always @(posedge clk) begin
      if (tb_we) begin
         buf_mem[tb_addr] <= tb_wdata;
         buf_wr[tb_addr]  <= 1'b1;
      end
      tb_rdata <= buf_val(tb_addr);
      pixel_in <= rom_bit(chr_val, row, col);
   end

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fail   = 0;
   int          we_count = 0;
   logic [19:0] exp_q[$];
   logic [7:0]  ref_mem [4096];
   logic        vid_auto = 1'b0;

   typedef struct {
      logic [9:0]  h;
      logic [9:0]  v;
      logic        act;
      logic [11:0] exp_addr;
   } vec_t;

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       act;
      logic       hs;
      logic       vs;
      logic [7:0] ch;
   } hist_t;

   vec_t  vecs [12];
   hist_t hist [P1];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   task automatic sample();
      logic [19:0] e;
      @(negedge clk);
      if (tb_we) begin
         we_count++;
         check("write_in_video_slot", 32'(active && hcount[2:0] == 3'd0), 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0d data %0h, required no write", tb_addr, tb_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr_data", {12'd0, tb_addr, tb_wdata}, {12'd0, e});
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      if (vid_auto) begin
         if (hcount == 10'd799) begin
            hcount = 10'd0;
            vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
         end else begin
            hcount = hcount + 10'd1;
         end
         active   = (hcount < 10'd640) && (vcount < 10'd480);
         hsync_in = !((hcount >= 10'd656) && (hcount < 10'd752));
         vsync_in = !((vcount >= 10'd490) && (vcount < 10'd492));
      end
   endtask

   task automatic host_write(input logic [11:0] a, input logic [7:0] d, input int hold);
      int lat, exp_lat, we0;
      exp_lat   = (active && hcount[2:0] == 3'd0) ? 2 : 1;
      we0       = we_count;
      host_addr = a;
      host_data = d;
      host_req  = 1'b1;
      if (32'(a) < 32'(CELLS)) begin
         exp_q.push_back({a, d});
         ref_mem[a] = d;
      end
      lat = -1;
      for (int c = 0; c < 6; c++) begin
         sample();
         if (host_ack) begin
            lat = c;
            break;
         end
         advance();
      end
      check("ack_latency", 32'(lat), 32'(exp_lat));
      for (int k = 0; k < hold; k++) begin
         advance();
         sample();
         check("ack_hold", 32'(host_ack), 32'd1);
      end
      advance();
      host_req = 1'b0;
      sample();
      check("ack_drop_cycle", 32'(host_ack), 32'd1);
      advance();
      sample();
      check("ack_release", 32'(host_ack), 32'd0);
      check("write_count", 32'(we_count - we0), (32'(a) < 32'(CELLS)) ? 32'd1 : 32'd0);
      advance();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [11:0] m_addr;
      logic [7:0]  m_ch;
      int          lat, diffs, m;

      for (int a = 0; a < 4096; a++) ref_mem[a] = init_val(12'(a));
      vecs[0]  = '{10'd40,   10'd16,   1'b1, 12'd85};
      vecs[1]  = '{10'd41,   10'd16,   1'b1, 12'd85};
      vecs[2]  = '{10'd0,    10'd0,    1'b1, 12'd0};
      vecs[3]  = '{10'd632,  10'd479,  1'b1, 12'd2399};
      vecs[4]  = '{10'd8,    10'd0,    1'b0, 12'd2399};
      vecs[5]  = '{10'd8,    10'd15,   1'b1, 12'd1};
      vecs[6]  = '{10'd639,  10'd200,  1'b1, 12'd1};
      vecs[7]  = '{10'd1016, 10'd511,  1'b1, 12'd2607};
      vecs[8]  = '{10'd1023, 10'd1023, 1'b1, 12'd2607};
      vecs[9]  = '{10'd64,   10'd1008, 1'b1, 12'd2488};
      vecs[10] = '{10'd16,   10'd32,   1'b0, 12'd2488};
      vecs[11] = '{10'd16,   10'd32,   1'b1, 12'd162};

      // ---- reset state, with raster and host inputs deliberately busy ----
      rst_n = 1'b0;
      hcount = 10'd41; vcount = 10'd16; active = 1'b1;
      hsync_in = 1'b0; vsync_in = 1'b0;
      host_req = 1'b1; host_addr = 12'd5; host_data = 8'hAA;
      repeat (3) @(posedge clk);
      #2;
      check("rst_host_ack", 32'(host_ack), 32'd0);
      check("rst_tb_we", 32'(tb_we), 32'd0);
      check("rst_tb_wdata", 32'(tb_wdata), 32'd0);
      check("rst_tb_addr_free", 32'(tb_addr), 32'd0);
      check("rst_chr_val", 32'(chr_val), 32'h20);
      check("rst_row", 32'(row), 32'd0);
      check("rst_col", 32'(col), 32'd0);
      check("rst_pixel_out", 32'(pixel_out), 32'd0);
      check("rst_hsync_out", 32'(hsync_out), 32'd1);
      check("rst_vsync_out", 32'(vsync_out), 32'd1);
      hcount = 10'd40;
      #1;
      check("rst_tb_addr_slot", 32'(tb_addr), 32'd0);
      host_req = 1'b0; active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      advance();

      // ---- load cell 85 through the host port, then fetch it ----
      vid_auto = 1'b1;
      host_write(12'd85, 8'h41, 1);
      vid_auto = 1'b0;
      hcount = 10'd40; vcount = 10'd16; active = 1'b1;
      sample();
      check("fetch_tb_addr", 32'(tb_addr), 32'd85);
      check("fetch_tb_we", 32'(tb_we), 32'd0);
      advance();
      hcount = 10'd41;
      sample();
      advance();
      hcount = 10'd42;
      sample();
      check("fetch_chr_val", 32'(chr_val), 32'h41);
      check("fetch_col", 32'(col), 32'd0);
      check("fetch_row", 32'(row), 32'd0);
      advance();

      // ---- address vector table ----
      for (int i = 0; i < 12; i++) begin
         hcount = vecs[i].h; vcount = vecs[i].v; active = vecs[i].act;
         sample();
         check($sformatf("vec%0d_tb_addr", i), 32'(tb_addr), 32'(vecs[i].exp_addr));
         check($sformatf("vec%0d_tb_we", i), 32'(tb_we), 32'd0);
         check($sformatf("vec%0d_tb_wdata", i), 32'(tb_wdata), 32'd0);
         advance();
      end

      // ---- randomized video stream against a pixel-level reference ----
      m_addr = 12'd0;
      m_ch   = 8'h20;
      for (int n = 0; n < P1; n++) begin
         if (n == 0) begin
            hcount = 10'd0;
            vcount = 10'($urandom_range(0, 479));
            active = 1'b1;
         end else begin
            if ($urandom_range(0, 15) == 0) begin
               hcount = 10'($urandom_range(0, 799));
               vcount = 10'($urandom_range(0, 524));
            end else begin
               hcount = (hcount == 10'd799) ? 10'd0 : hcount + 10'd1;
            end
            active = ($urandom_range(0, 4) != 0);
         end
         hsync_in = 1'($urandom_range(0, 1));
         vsync_in = 1'($urandom_range(0, 1));
         if (active && (hcount % 8 == 0)) begin
            m_addr = 12'(((32'(vcount) / 16) % 32) * COLS + 32'(hcount) / 8);
            m_ch   = ref_mem[m_addr];
         end
         hist[n] = '{hcount, vcount, active, hsync_in, vsync_in, m_ch};
         sample();
         check("p1_tb_addr", 32'(tb_addr), 32'(m_addr));
         check("p1_tb_we", 32'(tb_we), 32'd0);
         check("p1_host_ack", 32'(host_ack), 32'd0);
         if (n >= 2) begin
            m = n - 2;
            check("p1_chr_val", 32'(chr_val), 32'(hist[m].ch));
            check("p1_row", 32'(row), 32'(hist[m].v % 16));
            check("p1_col", 32'(col), 32'(hist[m].h % 8));
         end
         if (n >= 4) begin
            m = n - 4;
            check("p1_pixel_out", 32'(pixel_out),
                  32'(hist[m].act & rom_bit(hist[m].ch, 4'(hist[m].v % 16), 3'(hist[m].h % 8))));
            check("p1_hsync_out", 32'(hsync_out), 32'(hist[m].hs));
            check("p1_vsync_out", 32'(vsync_out), 32'(hist[m].vs));
         end
         advance();
      end

      // ---- collision with a video slot, long hold, out-of-range write ----
      vid_auto = 1'b1;
      hcount = 10'd32; vcount = 10'd100; active = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
      host_write(12'd100, 8'h5A, 8);
      hcount = 10'd33;
      host_write(12'd2400, 8'h99, 2);
      check("oob_cell_2400", 32'(buf_val(12'd2400)), 32'(init_val(12'd2400)));
      check("collision_cell_100", 32'(buf_val(12'd100)), 32'h5A);

      // ---- reset asserted while ACK is up ----
      host_addr = 12'd200; host_data = 8'h77; host_req = 1'b1;
      exp_q.push_back({12'd200, 8'h77});
      ref_mem[200] = 8'h77;
      lat = -1;
      for (int c = 0; c < 6; c++) begin
         sample();
         if (host_ack) begin
            lat = c;
            break;
         end
         advance();
      end
      check("rst_mid_ack_seen", 32'(host_ack), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_host_ack", 32'(host_ack), 32'd0);
      check("rst_mid_tb_we", 32'(tb_we), 32'd0);
      check("rst_mid_hsync_out", 32'(hsync_out), 32'd1);
      check("rst_mid_chr_val", 32'(chr_val), 32'h20);
      advance();
      sample();
      check("rst_held_host_ack", 32'(host_ack), 32'd0);
      host_req = 1'b0;
      rst_n = 1'b1;
      advance();

      // ---- randomized host traffic over a running raster ----
      hcount = 10'($urandom_range(0, 799));
      vcount = 10'($urandom_range(0, 479));
      active = (hcount < 10'd640);
      for (int t = 0; t < 60; t++) begin
         logic [11:0] a;
         a = ($urandom_range(0, 99) < 15) ? 12'($urandom_range(2400, 2600))
                                          : 12'($urandom_range(0, 2399));
         host_write(a, 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
         repeat ($urandom_range(0, 9)) begin
            sample();
            check("idle_host_ack", 32'(host_ack), 32'd0);
            advance();
         end
      end

      check("pending_writes", 32'(exp_q.size()), 32'd0);
      diffs = 0;
      for (int a = 0; a < 4096; a++) begin
         if (buf_val(12'(a)) != ref_mem[a]) diffs++;
      end
      check("mem_final_diffs", 32'(diffs), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
